// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared definitions for the 512x32 memory port controller.
// Holds the controller state encoding and the memory geometry constants.
package mem_if_pkg;

  localparam int unsigned MEM_ADDR_W = 9;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_DEPTH  = 512;

  // StWait is only reachable when the MEMIF_WAIT_EN build option is defined.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StDone
  } state_e;

endpackage

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: initiator-side controller for a single-port memory with synchronous write,
// asynchronous read and a shared address. Runs single or burst read/write transactions.
//
// Build option: MEMIF_WAIT_EN -- inserts WAIT_CYCLES wait cycles before every beat.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req, we, burst_len,   request and its attributes, sampled only while idle
//   start_addr
//   wr_data / wr_ready    write word for the current beat / beat committed this cycle
//   rd_data / rd_valid    registered read word / one-cycle pulse per read beat
//   busy, done            transaction in progress / one-cycle end-of-transaction pulse
//   mem_addr, mem_datain, memory-side address, write data, write enable, read data
//   mem_write, mem_dataout
module mem_port_ctrl
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned WAIT_CYCLES = 1,
  localparam int unsigned LEN_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dataout
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [LEN_W-1:0]  len_in;

  // Clamp only matters when MAX_BURST leaves unused codes in the length field.
  if ((1 << LEN_W) != MAX_BURST) begin : g_len_clamp
    localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_BURST - 1);
    assign len_in = (burst_len > LenMax) ? LenMax : burst_len;
  end else begin : g_len_pass
    assign len_in = burst_len;
  end

`ifdef MEMIF_WAIT_EN
  localparam int unsigned WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WaitLoad = WCNT_W'(WAIT_CYCLES - 1);
  // WAIT_CYCLES == 0 skips the wait state entirely.
  localparam state_e BeatEntry = (WAIT_CYCLES == 0) ? StAccess : StWait;
  logic [WCNT_W-1:0] wait_q, wait_d;
`else
  localparam state_e BeatEntry = StAccess;
  logic unused_wait_cycles;
  assign unused_wait_cycles = ^WAIT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    len_d      = len_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`ifdef MEMIF_WAIT_EN
    wait_d     = wait_q;
`endif
    case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = we;
          len_d   = len_in;
          addr_d  = start_addr;
          beat_d  = '0;
          state_d = BeatEntry;
`ifdef MEMIF_WAIT_EN
          wait_d  = WaitLoad;
`endif
        end
      end
`ifdef MEMIF_WAIT_EN
      StWait: begin
        if (wait_q == '0) begin
          state_d = StAccess;
        end else begin
          wait_d = wait_q - WCNT_W'(1);
        end
      end
`endif
      StAccess: begin
        if (!we_q) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_dataout;
        end
        addr_d = addr_q + ADDR_W'(1);
        beat_d = beat_q + LEN_W'(1);
        if (beat_q == len_q) begin
          state_d = StDone;
        end else begin
          state_d = BeatEntry;
`ifdef MEMIF_WAIT_EN
          wait_d  = WaitLoad;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef MEMIF_WAIT_EN
      wait_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef MEMIF_WAIT_EN
      wait_q     <= wait_d;
`endif
    end
  end

  always_comb begin
    mem_addr   = '0;
    mem_datain = '0;
    mem_write  = 1'b0;
    wr_ready   = 1'b0;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    if (state_q == StAccess || state_q == StWait) begin
      mem_addr = addr_q;
    end
    // Reset suppresses the strobe so the beat in flight when an abort lands is not committed.
    if (state_q == StAccess && we_q && !reset) begin
      mem_write  = 1'b1;
      wr_ready   = 1'b1;
      mem_datain = wr_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
